// File: rtl/fft_pingpong_ram_if.sv
// Handshake and data bundle between a frame writer, a frame reader and the
// ping-pong RAM. The RAM side uses modport slave; the producer/consumer
// side (or a testbench standing in for both) uses modport master.
interface fft_pingpong_ram_if #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 10
);
  // writer side
  logic                      wr_en;
  logic [ADDR_BIT_WIDTH-1:0] wr_addr;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic                      wr_done;
  logic                      wr_ready;
  // reader side
  logic                      rd_en;
  logic [ADDR_BIT_WIDTH-1:0] rd_addr;
  logic                      rd_done;
  logic                      rd_ready;
  logic [DATA_BIT_WIDTH-1:0] rd_data;
  logic                      rd_valid;
  // sticky protocol-error flags
  logic                      wr_err;
  logic                      rd_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    output wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Purpose : two-bank ping-pong frame buffer; writer fills one bank while the
//           reader drains the other, banks swap on wr_done / rd_done.
// Latency : read data registered, one cycle after an accepted rd_en;
//           ready flags reflect a swap on the cycle after the triggering edge.
// Backpr. : wr_ready / rd_ready gate every strobe; strobes seen while not
//           ready are dropped and latch wr_err / rd_err until reset.
// Ports   : clk, rst (async, active-high); bus (fft_pingpong_ram_if.slave)
//           carrying wr_en/wr_addr/wr_data/wr_done/wr_ready,
//           rd_en/rd_addr/rd_done/rd_ready/rd_data/rd_valid, wr_err/rd_err.
// Option  : define FFT_PINGPONG_BITREV_EN to bit-reverse rd_addr before it
//           indexes the bank array (write addressing is never reversed).
module fft_pingpong_ram #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  fft_pingpong_ram_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_BIT_WIDTH;

  // Both banks live in one array; the bank pointer is the address MSB.
  logic [DATA_BIT_WIDTH-1:0] mem_q [2*DEPTH];

  logic [1:0]                full_q,     full_d;
  logic                      wr_sel_q,   wr_sel_d;
  logic                      rd_sel_q,   rd_sel_d;
  logic [DATA_BIT_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      wr_err_q,   wr_err_d;
  logic                      rd_err_q,   rd_err_d;

  logic                      wr_ready, rd_ready;
  logic                      wr_fire, wr_done_fire, rd_fire, rd_done_fire;
  logic [ADDR_BIT_WIDTH-1:0] rd_addr_eff;

  // Ready flags come straight from registers: no input-to-output path.
  assign wr_ready = ~full_q[wr_sel_q];
  assign rd_ready =  full_q[rd_sel_q];

  assign wr_fire      = bus.wr_en   & wr_ready;
  assign wr_done_fire = bus.wr_done & wr_ready;
  assign rd_fire      = bus.rd_en   & rd_ready;
  assign rd_done_fire = bus.rd_done & rd_ready;

`ifdef FFT_PINGPONG_BITREV_EN
  always_comb begin
    rd_addr_eff = '0;
    for (int i = 0; i < ADDR_BIT_WIDTH; i++) begin
      rd_addr_eff[i] = bus.rd_addr[ADDR_BIT_WIDTH-1-i];
    end
  end
`else
  assign rd_addr_eff = bus.rd_addr;
`endif

  always_comb begin
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_err_d   = wr_err_q;
    rd_err_d   = rd_err_q;

    // wr_ready implies the write bank is empty and rd_ready implies the read
    // bank is full, so the two done events always touch different banks.
    if (wr_done_fire) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (rd_done_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

    // Read uses the pre-swap pointer, so a read alongside rd_done still
    // comes from the frame being released.
    if (rd_fire) begin
      rd_data_d  = mem_q[{rd_sel_q, rd_addr_eff}];
      rd_valid_d = 1'b1;
    end

    if ((bus.wr_en | bus.wr_done) & ~wr_ready) wr_err_d = 1'b1;
    if ((bus.rd_en | bus.rd_done) & ~rd_ready) rd_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage is not reset; a reset empties both banks logically, which is
  // enough to make stale contents unreadable.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{wr_sel_q, bus.wr_addr}] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.rd_err   = rd_err_q;
endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram with 3-bit addressing so the optional
// bit-reversed read path can be exercised on a small bank.
module tb_fft_pingpong_ram;
  localparam int DW = 32;
  localparam int AW = 3;
`ifdef FFT_PINGPONG_BITREV_EN
  localparam logic [AW-1:0] RA1 = 3'd4;  // reversed image of address 1
`else
  localparam logic [AW-1:0] RA1 = 3'd1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fft_pingpong_ram_if #(.DATA_BIT_WIDTH(DW), .ADDR_BIT_WIDTH(AW)) bus ();

  fft_pingpong_ram #(.DATA_BIT_WIDTH(DW), .ADDR_BIT_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic wen, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata, input logic wdone,
                       input logic ren, input logic [AW-1:0] raddr,
                       input logic rdone);
    bus.wr_en   = wen;
    bus.wr_addr = waddr;
    bus.wr_data = wdata;
    bus.wr_done = wdone;
    bus.rd_en   = ren;
    bus.rd_addr = raddr;
    bus.rd_done = rdone;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_wr_ready"}, {31'd0, bus.wr_ready}, 32'd1);
    check({pfx, "_rd_ready"}, {31'd0, bus.rd_ready}, 32'd0);
    check({pfx, "_rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
    check({pfx, "_rd_data"},  bus.rd_data,           32'd0);
    check({pfx, "_wr_err"},   {31'd0, bus.wr_err},   32'd0);
    check({pfx, "_rd_err"},   {31'd0, bus.rd_err},   32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // Read while nothing is ready: dropped, sticky rd_err
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
    check("early_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("early_rd_err",   {31'd0, bus.rd_err},   32'd1);
    check("early_wr_err",   {31'd0, bus.wr_err},   32'd0);
    repeat (3) idle();
    check("rd_err_sticky",  {31'd0, bus.rd_err},   32'd1);
    rst = 1'b1;
    #2;
    check("rd_err_cleared", {31'd0, bus.rd_err},   32'd0);
    rst = 1'b0;
    idle();

    // Frame A into bank 0, done on last write
    drive(1'b1, 3'd0, 32'hA0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd1, 32'hA1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd2, 32'hA2, 1'b0, 1'b0, '0, 1'b0);
    check("A_rd_ready_pre", {31'd0, bus.rd_ready}, 32'd0);
    drive(1'b1, 3'd3, 32'hA3, 1'b1, 1'b0, '0, 1'b0);
    check("A_wr_ready",     {31'd0, bus.wr_ready}, 32'd1);
    check("A_rd_ready",     {31'd0, bus.rd_ready}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd2, 1'b0);
    check("A_rd2_data",     bus.rd_data,           32'hA2);
    check("A_rd2_valid",    {31'd0, bus.rd_valid}, 32'd1);
    idle();
    check("A_idle_valid",   {31'd0, bus.rd_valid}, 32'd0);
    check("A_idle_hold",    bus.rd_data,           32'hA2);

    // Frame B into bank 1; both banks now full
    drive(1'b1, 3'd0, 32'hB0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd1, 32'h55, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd2, 32'hB2, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd3, 32'hB3, 1'b1, 1'b0, '0, 1'b0);
    check("B_wr_ready",     {31'd0, bus.wr_ready}, 32'd0);
    check("B_rd_ready",     {31'd0, bus.rd_ready}, 32'd1);
    drive(1'b1, 3'd2, 32'hDEAD, 1'b0, 1'b0, '0, 1'b0);
    check("ovf_wr_err",     {31'd0, bus.wr_err},   32'd1);
    check("ovf_wr_ready",   {31'd0, bus.wr_ready}, 32'd0);

    // Read in the same cycle as rd_done comes from the released bank 0
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b1);
    check("swap_rd_data",   bus.rd_data,           32'hA0);
    check("swap_wr_ready",  {31'd0, bus.wr_ready}, 32'd1);
    check("swap_rd_ready",  {31'd0, bus.rd_ready}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd2, 1'b0);
    check("B_unchanged",    bus.rd_data,           32'hB2);
    drive(1'b0, '0, '0, 1'b0, 1'b1, RA1, 1'b0);
    check("bitrev_rd",      bus.rd_data,           32'h55);

    // Frame C into bank 0 with wr_done and rd_done (bank 1) together
    drive(1'b1, 3'd0, 32'hC0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd1, 32'hC1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd2, 32'hC2, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd3, 32'hC3, 1'b1, 1'b0, '0, 1'b1);
    check("C_wr_ready",     {31'd0, bus.wr_ready}, 32'd1);
    check("C_rd_ready",     {31'd0, bus.rd_ready}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
    check("C_rd0",          bus.rd_data,           32'hC0);

    // Frame D into bank 1, wr_done (bank 1) with rd_done (bank 0)
    drive(1'b1, 3'd0, 32'hD0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd1, 32'hD1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd2, 32'hD2, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd3, 32'hD3, 1'b1, 1'b0, '0, 1'b1);
    check("D_wr_ready",     {31'd0, bus.wr_ready}, 32'd1);
    check("D_rd_ready",     {31'd0, bus.rd_ready}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
    check("D_rd0",          bus.rd_data,           32'hD0);
    check("wr_err_sticky",  {31'd0, bus.wr_err},   32'd1);

    // Release bank 1, refill bank 0, then start bank 1 and reset mid-frame
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("empty_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
    drive(1'b1, 3'd0, 32'hE0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd1, 32'hE1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd2, 32'hE2, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd3, 32'hE3, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 3'd0, 32'hF0, 1'b0, 1'b1, 3'd0, 1'b0);
    check("E_rd0",          bus.rd_data,           32'hE0);
    check("E_rd_valid",     {31'd0, bus.rd_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    bus.wr_en = 1'b0; bus.wr_done = 1'b0; bus.rd_en = 1'b0; bus.rd_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
    check("post_rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("post_rst_err",   {31'd0, bus.rd_err},   32'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
